// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the request-driven clock-gate controller.
package clk_gate_ctrl_pkg;

  localparam int CntWidth = 8;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam cnt_t CntZero = 8'd0;
  localparam cnt_t CntOne  = 8'd1;

  // Counter preload for a delay of `cycles` edges; a zero delay never loads the counter.
  function automatic cnt_t load_value(input int cycles);
    cnt_t value;
    if (cycles > 0) begin
      value = cnt_t'(cycles - 1);
    end else begin
      value = CntZero;
    end
    return value;
  endfunction

endpackage

// File: rtl/tc_clk_gating.sv
// Latch-based integrated clock gate: the enable is captured while clk_i is low,
// so clk_o can only start or stop on a rising edge of a full high phase.
module tc_clk_gating #(
  parameter bit IS_FUNCTIONAL = 1'b1
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  generate
    if (IS_FUNCTIONAL) begin : g_icg
      logic en_latch_r;

      // Transparent-low enable latch.
      always_latch begin
        if (!clk_i) begin
          en_latch_r <= en_i | test_en_i;
        end
      end

      assign clk_o = clk_i & en_latch_r;
    end else begin : g_bypass
      assign clk_o = clk_i;
    end
  endgenerate

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: wakes the gated clock on any request, waits a settle
// delay before granting, and re-gates after an idle hysteresis.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int WakeCycles = 2,
  parameter int IdleCycles = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              force_on_i,
  input  logic              test_en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              clk_o,
  output logic              active_o,
  output logic [1:0]        state_o
);

  localparam cnt_t WakeLoad = load_value(WakeCycles);
  localparam cnt_t IdleLoad = load_value(IdleCycles);

  state_e state_r;
  state_e state_s;
  cnt_t   cnt_r;
  cnt_t   cnt_s;
  logic   en_r;
  logic   any_req_s;
  logic   grant_window_s;

  assign any_req_s = (|req_i) | force_on_i;

  // Next-state and counter logic; the counter only moves while it is non-zero.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_OFF: begin
        if (any_req_s) begin
          if (WakeCycles == 0) begin
            state_s = ST_ON;
            cnt_s   = CntZero;
          end else begin
            state_s = ST_WAKE;
            cnt_s   = WakeLoad;
          end
        end else begin
          state_s = ST_OFF;
          cnt_s   = CntZero;
        end
      end
      ST_WAKE: begin
        // Wake always completes, even if every request has already gone away.
        if (cnt_r == CntZero) begin
          state_s = ST_ON;
          cnt_s   = CntZero;
        end else begin
          state_s = ST_WAKE;
          cnt_s   = cnt_r - CntOne;
        end
      end
      ST_ON: begin
        if (any_req_s) begin
          state_s = ST_ON;
          cnt_s   = CntZero;
        end else if (IdleCycles == 0) begin
          state_s = ST_OFF;
          cnt_s   = CntZero;
        end else begin
          state_s = ST_DRAIN;
          cnt_s   = IdleLoad;
        end
      end
      ST_DRAIN: begin
        if (any_req_s) begin
          state_s = ST_ON;
          cnt_s   = CntZero;
        end else if (cnt_r == CntZero) begin
          state_s = ST_OFF;
          cnt_s   = CntZero;
        end else begin
          state_s = ST_DRAIN;
          cnt_s   = cnt_r - CntOne;
        end
      end
      default: begin
        state_s = ST_OFF;
        cnt_s   = CntZero;
      end
    endcase
  end

  // State, counter and gate-enable registers; enable is registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_OFF;
      cnt_r   <= CntZero;
      en_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      en_r    <= (state_s != ST_OFF);
    end
  end

  // Grants only depend on registered state, so a late request in ON/DRAIN is granted at once.
  assign grant_window_s = (state_r == ST_ON) || (state_r == ST_DRAIN);
  assign gnt_o          = req_i & {NumReq{grant_window_s}};
  assign active_o       = en_r;
  assign state_o        = state_r;

  tc_clk_gating #(
    .IS_FUNCTIONAL(1'b1)
  ) u_icg (
    .clk_i    (clk_i),
    .en_i     (en_r),
    .test_en_i(test_en_i),
    .clk_o    (clk_o)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: two configurations (2/3 and 0/0 cycle delays) run in
// lock-step against an edge-counting reference model of the wake/idle rules.
module tb_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_on;
  logic       test_en;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic       clk_a, clk_b;
  logic       act_a, act_b;
  logic [1:0] st_a, st_b;

  int errors = 0;
  int checks = 0;

  // Reference model: awake flag plus edges left until grant / until re-gating.
  int awake[2];
  int wake_left[2];
  int idle_left[2];
  int cfg_wake[2] = '{2, 0};
  int cfg_idle[2] = '{3, 0};

  always #5 clk = ~clk;

  clk_gate_ctrl #(.NumReq(4), .WakeCycles(2), .IdleCycles(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .force_on_i(force_on), .test_en_i(test_en),
    .gnt_o(gnt_a), .clk_o(clk_a), .active_o(act_a), .state_o(st_a)
  );

  clk_gate_ctrl #(.NumReq(4), .WakeCycles(0), .IdleCycles(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .force_on_i(force_on), .test_en_i(test_en),
    .gnt_o(gnt_b), .clk_o(clk_b), .active_o(act_b), .state_o(st_b)
  );

  function automatic logic [7:0] m_state(input int k);
    if (awake[k] == 0) return 8'd0;
    if (wake_left[k] > 0) return 8'd1;
    if (idle_left[k] > 0) return 8'd3;
    return 8'd2;
  endfunction

  function automatic logic [7:0] m_gnt(input int k);
    if (m_state(k) >= 8'd2) return {4'd0, req};
    return 8'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      awake[k] = 0; wake_left[k] = 0; idle_left[k] = 0;
    end
  endtask

  task automatic model_edge();
    int any_req;
    any_req = ((req != 4'd0) || force_on) ? 1 : 0;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (awake[k] == 0) begin
          if (any_req != 0) begin
            awake[k] = 1; wake_left[k] = cfg_wake[k]; idle_left[k] = 0;
          end
        end else if (wake_left[k] > 0) begin
          wake_left[k]--;
        end else if (any_req != 0) begin
          idle_left[k] = 0;
        end else if (idle_left[k] > 0) begin
          idle_left[k]--;
          if (idle_left[k] == 0) awake[k] = 0;
        end else begin
          idle_left[k] = cfg_idle[k];
          if (cfg_idle[k] == 0) awake[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fsm(input string tag);
    chk({tag, "/a.state"}, {6'd0, st_a}, m_state(0));
    chk({tag, "/a.active"}, {7'd0, act_a}, (awake[0] != 0) ? 8'd1 : 8'd0);
    chk({tag, "/a.gnt"}, {4'd0, gnt_a}, m_gnt(0));
    chk({tag, "/b.state"}, {6'd0, st_b}, m_state(1));
    chk({tag, "/b.active"}, {7'd0, act_b}, (awake[1] != 0) ? 8'd1 : 8'd0);
    chk({tag, "/b.gnt"}, {4'd0, gnt_b}, m_gnt(1));
  endtask

  // Inputs change only in the low phase; outputs are checked 1 time unit later.
  task automatic apply(input logic [3:0] r, input logic f, input logic t, input logic rs,
                       input string tag);
    req = r; force_on = f; test_en = t; rst = rs;
    if (rs) model_reset();
    #1;
    check_fsm(tag);
    chk({tag, "/a.clk_low"}, {7'd0, clk_a}, 8'd0);
    chk({tag, "/b.clk_low"}, {7'd0, clk_b}, 8'd0);
  endtask

  // One rising edge: clk_o in the high phase must reflect the enable captured before it.
  task automatic step(input string tag);
    logic pa, pb;
    pa = (awake[0] != 0);
    pb = (awake[1] != 0);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "/a.clk_high"}, {7'd0, clk_a}, {7'd0, pa | test_en});
    chk({tag, "/b.clk_high"}, {7'd0, clk_b}, {7'd0, pb | test_en});
    check_fsm(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] r;
    logic       f, t, rs;

    model_reset();
    req = 4'd0; force_on = 1'b0; test_en = 1'b0; rst = 1'b1;
    step("reset0");
    apply(4'b1111, 1'b1, 1'b0, 1'b1, "reset_req");
    step("reset_req_edge");
    chk("reset.state_a", {6'd0, st_a}, 8'd0);

    // Wake latency with WakeCycles=2 and WakeCycles=0
    apply(4'b0000, 1'b0, 1'b0, 1'b0, "release");
    step("release_edge");
    apply(4'b0001, 1'b0, 1'b0, 1'b0, "wake_req");
    step("wake1");
    chk("wake1.a_is_wake", {6'd0, st_a}, 8'd1);
    chk("wake1.b_is_on", {6'd0, st_b}, 8'd2);
    chk("wake1.b_gnt", {4'd0, gnt_b}, 8'd1);
    step("wake2");
    chk("wake2.a_gnt_low", {4'd0, gnt_a}, 8'd0);
    step("wake3");
    chk("wake3.a_is_on", {6'd0, st_a}, 8'd2);
    chk("wake3.a_gnt", {4'd0, gnt_a}, 8'd1);

    // Drain with IdleCycles=3 and immediate re-gate with IdleCycles=0
    apply(4'b0000, 1'b0, 1'b0, 1'b0, "drop");
    step("drain1");
    chk("drain1.b_off", {6'd0, st_b}, 8'd0);
    step("drain2");
    step("drain3");
    chk("drain3.a_drain", {6'd0, st_a}, 8'd3);
    step("drain4");
    chk("drain4.a_off", {6'd0, st_a}, 8'd0);
    chk("drain4.a_inactive", {7'd0, act_a}, 8'd0);
    step("off_idle");

    // Late request during DRAIN with one count left
    apply(4'b0001, 1'b0, 1'b0, 1'b0, "rewake");
    for (int i = 0; i < 3; i++) step("rewake_edge");
    apply(4'b0000, 1'b0, 1'b0, 1'b0, "redrop");
    step("redrain1");
    step("redrain2");
    apply(4'b0100, 1'b0, 1'b0, 1'b0, "late_req");
    chk("late_req.a_gnt", {4'd0, gnt_a}, 8'h04);
    step("late_req_edge");
    chk("late_req.a_on", {6'd0, st_a}, 8'd2);

    // Hand-over between requesters, then software force
    apply(4'b0010, 1'b0, 1'b0, 1'b0, "handover");
    step("handover_edge");
    chk("handover.a_on", {6'd0, st_a}, 8'd2);
    apply(4'b0000, 1'b1, 1'b0, 1'b0, "force");
    step("force1");
    step("force2");
    chk("force.a_on", {6'd0, st_a}, 8'd2);

    // Asynchronous reset mid-WAKE and mid-ON
    apply(4'b0000, 1'b0, 1'b0, 1'b0, "settle");
    for (int i = 0; i < 4; i++) step("settle_edge");
    apply(4'b0001, 1'b0, 1'b0, 1'b0, "rst_wake_req");
    step("rst_wake_edge");
    #2;
    apply(4'b0001, 1'b0, 1'b0, 1'b1, "rst_mid_wake");
    step("rst_wake_hold");
    apply(4'b0001, 1'b0, 1'b0, 1'b0, "rst_wake_release");
    step("restart1");
    chk("restart.a_wake", {6'd0, st_a}, 8'd1);
    step("restart2");
    step("restart3");
    #2;
    apply(4'b0001, 1'b0, 1'b0, 1'b1, "rst_mid_on");
    chk("rst_mid_on.a_state", {6'd0, st_a}, 8'd0);
    step("rst_on_hold");
    apply(4'b0000, 1'b0, 1'b0, 1'b0, "rst_on_release");
    step("rst_on_release_edge");

    // Test enable with no requests
    apply(4'b0000, 1'b0, 1'b1, 1'b0, "test_en");
    for (int i = 0; i < 3; i++) step("test_en_edge");
    chk("test_en.a_state", {6'd0, st_a}, 8'd0);
    chk("test_en.b_gnt", {4'd0, gnt_b}, 8'd0);

    // Randomized traffic against the model
    r = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom);
      if ($urandom_range(0, 9) == 0) r = 4'd0;
      f  = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 14) == 0);
      rs = ($urandom_range(0, 59) == 0);
      apply(r, f, t, rs, "rand");
      step("rand_edge");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
